// File: rtl/axi_sram_slave_if.sv
// rtl/axi_sram_slave_if.sv - AR/R/AW/W channel bundle between the RAM arbiter and the SRAM slave
interface axi_sram_slave_if;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_bits_addr;
  logic        r_ready;
  logic        r_valid;
  logic [63:0] r_bits_data;
  logic [1:0]  r_rresp;
  logic        r_bits_last;
  logic        aw_valid;
  logic        aw_ready;
  logic [63:0] aw_bits_addr;
  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_bits_data;
  logic [7:0]  w_bits_strb;

  modport master (
    output ar_valid, ar_bits_addr, r_ready, aw_valid, aw_bits_addr,
           w_valid, w_bits_data, w_bits_strb,
    input  ar_ready, r_valid, r_bits_data, r_rresp, r_bits_last, aw_ready, w_ready
  );

  modport slave (
    input  ar_valid, ar_bits_addr, r_ready, aw_valid, aw_bits_addr,
           w_valid, w_bits_data, w_bits_strb,
    output ar_ready, r_valid, r_bits_data, r_rresp, r_bits_last, aw_ready, w_ready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-beat 64-bit AXI-style SRAM slave (no B channel)
// Optional macro AXI_SRAM_RAND_DELAY_EN adds LFSR-driven read delay and w_ready gating.
module axi_sram_slave #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic            clock,
  input  logic            reset,
  axi_sram_slave_if.slave io
);
  localparam logic [63:0] SIZE_BYTES = 64'd8 << DEPTH_LOG2;
  localparam logic [3:0]  LAT        = 4'(RD_LAT);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID} r_state_t;
  typedef enum logic {W_IDLE, W_COMMIT} w_state_t;

  logic [63:0] mem [1 << DEPTH_LOG2];

  function automatic logic in_range(input logic [63:0] addr);
    return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < SIZE_BYTES);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [63:0] addr);
    return DEPTH_LOG2'((addr - BASE_ADDR) >> 3);
  endfunction

  logic [1:0] extra_wait;
  logic       w_gate;
`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign extra_wait = lfsr[1:0];
  assign w_gate     = lfsr[2];
`else
  assign extra_wait = 2'd0;
  assign w_gate     = 1'b1;
`endif

  r_state_t    r_state, r_next;
  logic [3:0]  r_cnt, r_cnt_next, lat_total;
  logic [63:0] r_addr, r_data, cap_addr;
  logic [1:0]  r_resp;
  logic        ar_fire, cap_en;

  assign lat_total = LAT + {2'b00, extra_wait};
  assign ar_fire   = io.ar_valid && (r_state == R_IDLE);

  // Capture happens in the last cycle before R_VALID; with a total latency of 1 that is the AR cycle.
  always_comb begin
    r_next         = r_state;
    r_cnt_next     = r_cnt;
    cap_en         = 1'b0;
    cap_addr       = r_addr;
    io.ar_ready    = !reset && (r_state == R_IDLE);
    io.r_valid     = !reset && (r_state == R_VALID);
    io.r_bits_last = !reset && (r_state == R_VALID);
    io.r_bits_data = reset ? 64'd0 : r_data;
    io.r_rresp     = reset ? 2'b00 : r_resp;
    case (r_state)
      R_IDLE: begin
        if (io.ar_valid) begin
          r_cnt_next = lat_total;
          cap_addr   = io.ar_bits_addr;
          if (lat_total == 4'd1) begin
            r_next = R_VALID;
            cap_en = 1'b1;
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        r_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd2) begin
          r_next = R_VALID;
          cap_en = 1'b1;
        end
      end
      R_VALID: if (io.r_ready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 64'd0;
      r_data  <= 64'd0;
      r_resp  <= 2'b00;
    end else begin
      r_state <= r_next;
      r_cnt   <= r_cnt_next;
      if (ar_fire) r_addr <= io.ar_bits_addr;
      if (cap_en) begin
        r_data <= in_range(cap_addr) ? mem[word_index(cap_addr)] : 64'd0;
        r_resp <= in_range(cap_addr) ? 2'b00 : 2'b10;
      end
    end
  end

  w_state_t    w_state, w_next;
  logic        aw_got, w_got, aw_fire, w_fire, commit;
  logic [63:0] aw_addr, w_data;
  logic [7:0]  w_strb;

  always_comb begin
    w_next      = w_state;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    commit      = 1'b0;
    io.aw_ready = 1'b0;
    io.w_ready  = 1'b0;
    case (w_state)
      W_IDLE: begin
        io.aw_ready = !reset && !aw_got;
        io.w_ready  = !reset && !w_got && w_gate;
        aw_fire     = io.aw_valid && !aw_got && !reset;
        w_fire      = io.w_valid && !w_got && w_gate && !reset;
        if ((aw_got || aw_fire) && (w_got || w_fire)) w_next = W_COMMIT;
      end
      W_COMMIT: begin
        commit = 1'b1;
        w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_addr <= 64'd0;
      w_data  <= 64'd0;
      w_strb  <= 8'd0;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        aw_got  <= 1'b1;
        aw_addr <= io.aw_bits_addr;
      end
      if (w_fire) begin
        w_got  <= 1'b1;
        w_data <= io.w_bits_data;
        w_strb <= io.w_bits_strb;
      end
      if (commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  // The array has no reset; a commit cycle under reset is abandoned.
  always_ff @(posedge clock) begin
    if (!reset && commit && in_range(aw_addr)) begin
      for (int i = 0; i < 8; i++) begin
        if (w_strb[i]) mem[word_index(aw_addr)][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - scoreboard bench for axi_sram_slave at RD_LAT 1 and 4
module tb_axi_sram_slave;
  localparam logic [63:0] BASE = 64'h8000_0000;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ar_valid = 1'b0, r_ready = 1'b1, aw_valid = 1'b0, w_valid = 1'b0;
  logic [63:0] ar_addr = '0, aw_addr = '0, w_data = '0;
  logic [7:0]  w_strb = '0;
  logic [1:0]  ar_rdy, r_vld, aw_rdy, w_rdy, out_or;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] model [int unsigned];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t expect_for(input logic [63:0] a);
    exp_t e;
    int unsigned idx;
    e.t = 0;
    if (a >= BASE && a < BASE + 64'h8000) begin
      idx    = int'((a - BASE) >> 3);
      e.data = model.exists(idx) ? model[idx] : 64'd0;
      e.resp = 2'b00;
    end else begin
      e.data = 64'd0;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 4;
    axi_sram_slave_if io ();
    exp_t sb [$];
    exp_t e;
    bit   seen;
    bit   ar_chk;

    assign io.ar_valid     = ar_valid;
    assign io.ar_bits_addr = ar_addr;
    assign io.r_ready      = r_ready;
    assign io.aw_valid     = aw_valid;
    assign io.aw_bits_addr = aw_addr;
    assign io.w_valid      = w_valid;
    assign io.w_bits_data  = w_data;
    assign io.w_bits_strb  = w_strb;
    assign ar_rdy[g] = io.ar_ready;
    assign r_vld[g]  = io.r_valid;
    assign aw_rdy[g] = io.aw_ready;
    assign w_rdy[g]  = io.w_ready;
    assign out_or[g] = |{io.ar_ready, io.r_valid, io.r_bits_data, io.r_rresp,
                         io.r_bits_last, io.aw_ready, io.w_ready};

    axi_sram_slave #(.DEPTH_LOG2(12), .BASE_ADDR(BASE), .RD_LAT(LAT)) u_dut (
      .clock(clk),
      .reset(reset),
      .io   (io)
    );

    // Inputs change just after posedge, so the negedge sees the values the next edge will act on.
    always @(negedge clk) begin
      if (reset) begin
        sb.delete();
        seen   = 1'b0;
        ar_chk = 1'b0;
      end else begin
        if (ar_chk) begin
          check_eq($sformatf("ar_ready_after_r%0d", g), io.ar_ready, 1'b1);
          ar_chk = 1'b0;
        end
        if (io.ar_valid && io.ar_ready) begin
          e   = expect_for(io.ar_bits_addr);
          e.t = cyc;
          sb.push_back(e);
        end
        if (io.r_valid) begin
          if (sb.size() == 0) begin
            check_eq($sformatf("r_valid_unexpected%0d", g), io.r_valid, 1'b0);
          end else begin
            e = sb[0];
            if (!seen) begin
              check_eq($sformatf("r_latency%0d", g), 64'(cyc - e.t), 64'(LAT));
              seen = 1'b1;
            end
            check_eq($sformatf("r_data%0d", g), io.r_bits_data, e.data);
            check_eq($sformatf("r_resp%0d", g), io.r_rresp, e.resp);
            check_eq($sformatf("r_last%0d", g), io.r_bits_last, 1'b1);
            check_eq($sformatf("ar_ready_busy%0d", g), io.ar_ready, 1'b0);
            if (io.r_ready) begin
              void'(sb.pop_front());
              seen   = 1'b0;
              ar_chk = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int w_lead);
    logic [63:0] m;
    int unsigned idx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (aw_rdy == 2'b11 && w_rdy == 2'b11) break;
    end
    check_eq("w_idle_ready", {aw_rdy, w_rdy}, 4'hF);
    @(posedge clk); #1;
    w_valid = 1'b1; w_data = d; w_strb = s;
    if (w_lead == 0) begin
      aw_valid = 1'b1; aw_addr = a;
    end
    @(posedge clk); #1;
    w_valid = 1'b0; aw_valid = 1'b0;
    for (int k = 1; k <= w_lead; k++) begin
      if (k == w_lead) begin
        aw_valid = 1'b1; aw_addr = a;
      end
      @(negedge clk);
      check_eq("w_ready_held", w_rdy, 2'b00);
      check_eq("aw_ready_wait", aw_rdy, 2'b11);
      @(posedge clk); #1;
      aw_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("commit_readies", {aw_rdy, w_rdy}, 4'h0);
    @(negedge clk);
    check_eq("post_commit_readies", {aw_rdy, w_rdy}, 4'hF);
    if (a >= BASE && a < BASE + 64'h8000) begin
      idx = int'((a - BASE) >> 3);
      m   = model.exists(idx) ? model[idx] : 64'd0;
      for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = d[8*i +: 8];
      model[idx] = m;
    end
  endtask

  task automatic do_read(input logic [63:0] a, input int hold);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ar_rdy == 2'b11) break;
    end
    check_eq("ar_idle", ar_rdy, 2'b11);
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_addr = a; r_ready = (hold == 0);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    if (hold > 0) begin
      repeat (3 + hold) @(posedge clk);
      #1 r_ready = 1'b1;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (g_dut[0].sb.size() == 0 && g_dut[1].sb.size() == 0) break;
    end
    check_eq("r_drain", 64'(g_dut[0].sb.size() + g_dut[1].sb.size()), 64'd0);
  endtask

  initial begin
    int unsigned ridx;
    logic [63:0] ra;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", out_or, 2'b00);
    @(posedge clk); #1 reset = 1'b0;

    do_write(BASE, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    do_write(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0);
    do_read(64'h8000_0010, 0);
    do_write(64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0);
    do_read(64'h8000_0010, 0);
    check_eq("partial_strobe_model", model[2], 64'h1122_3344_AAAA_AAAA);
    do_read(64'h8000_0010, 5);
    do_write(64'h8000_7FF8, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 3);
    do_read(64'h8000_7FF8, 0);
    do_read(64'h7FFF_FFF8, 0);
    do_read(64'h8000_8000, 0);
    do_write(64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    do_read(BASE, 0);

    for (int n = 0; n < 6; n++) begin
      ridx = $urandom_range(1, 4094);
      ra   = BASE + 64'(ridx) * 64'd8;
      do_write(ra, {$urandom, $urandom}, 8'hFF, 0);
      do_write(ra, {$urandom, $urandom}, 8'($urandom_range(1, 254)), n % 2);
      do_read(ra, 0);
    end

    // Abort a read while the RD_LAT=4 instance is still in R_WAIT.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ar_rdy == 2'b11) break;
    end
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_addr = BASE;
    @(posedge clk); #1;
    ar_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_reset_r_valid", r_vld, 2'b00);
      check_eq("post_reset_ar_ready", ar_rdy, 2'b11);
    end
    do_read(64'h8000_0010, 0);
    do_read(64'h8000_7FF8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- Single-port-per-channel AXI-style memory slave on the `sram` side of the IFU/LSU RAM arbiter.
- Consumes arbitrated AR/R/AW/W traffic and serves single-beat 64-bit reads and writes from an internal word array.
- No B channel; a write is complete once its data handshake is accepted.
- Used as the simulation main memory behind the arbiter.

Parameters:
- DEPTH_LOG2, 12, log2 of number of 64-bit words (default 32 KiB).
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- RD_LAT, 1, cycles from AR handshake to first `r_valid` cycle; legal range 1..8.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- io_ar_valid  input  1  read address valid
- io_ar_ready  output  1  read address accepted
- io_ar_bits_addr  input  64  read byte address
- io_r_ready  input  1  read data consumer ready
- io_r_valid  output  1  read data valid
- io_r_bits_data  output  64  read data
- io_r_rresp  output  2  2'b00 OKAY, 2'b10 SLVERR
- io_r_bits_last  output  1  last beat; always equal to `io_r_valid`
- io_aw_valid  input  1  write address valid
- io_aw_ready  output  1  write address accepted
- io_aw_bits_addr  input  64  write byte address
- io_w_valid  input  1  write data valid
- io_w_ready  output  1  write data accepted
- io_w_bits_data  input  64  write data
- io_w_bits_strb  input  8  byte enables; bit i enables data[8i+7:8i]

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high on `reset`.
- Reset values:
  - While `reset` is high, all ready/valid outputs are 0; `r_bits_data`=0, `r_rresp`=0, `r_bits_last`=0.
  - Both FSMs go to IDLE and all latched flags and registers clear.
  - Array contents are not cleared.
  - Reset asserted mid-transaction aborts it: a pending R beat is dropped and a half-collected write is discarded.
- Address decode:
  - In range iff BASE_ADDR <= addr < BASE_ADDR + (8 << DEPTH_LOG2).
  - index = (addr - BASE_ADDR) >> 3, truncated to DEPTH_LOG2 bits.
  - addr[2:0] is ignored; transfers are always full-word with strobes.
- Read FSM states R_IDLE, R_WAIT, R_VALID:
  - R_IDLE: `ar_ready`=1. On `ar_valid`&&`ar_ready` in cycle T, latch the address and load the wait counter with RD_LAT.
    - If RD_LAT=1, go straight to R_VALID.
    - Otherwise go to R_WAIT.
  - R_WAIT: `ar_ready`=0. Counter decrements each cycle; go to R_VALID when it reaches 1, so `r_valid` first asserts in cycle T+RD_LAT.
  - Data capture: the array is read into the data register at the end of cycle T+RD_LAT-1.
  - R_VALID: `r_valid`=`r_bits_last`=1; data and resp held stable until `r_ready`. On the handshake, return to R_IDLE; `ar_ready`=1 the next cycle.
  - Throughput: at most one read per RD_LAT+1 cycles.
  - Out-of-range read: `rresp`=2'b10, data=0, same timing.
- Write FSM states W_IDLE, W_COMMIT:
  - AW collection: `aw_ready`=1 until an AW handshake latches the address and sets `aw_got`; `aw_ready`=0 while `aw_got`.
  - W collection: `w_ready`=1 until a W handshake latches data and strobe and sets `w_got`; `w_ready`=0 while `w_got`.
  - AW and W may arrive in either order or in the same cycle.
  - Once both are held (including the cycle the second arrives), enter W_COMMIT next cycle. `aw_ready`=`w_ready`=0 in W_COMMIT.
  - W_COMMIT: apply the byte-strobed write at the end of the cycle, clear both flags, return to W_IDLE.
  - Out-of-range write: silently dropped.
- Read/write ordering: read and write FSMs run independently. If a W_COMMIT cycle equals a read capture cycle at the same index, the read returns old data (read-before-write). Writes committed in any earlier cycle are visible.

Optional Feature:
- Macro AXI_SRAM_RAND_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle.
  - At each AR handshake, `lfsr[1:0]` extra wait cycles (0..3) are added to RD_LAT.
  - In W_IDLE, `w_ready` is additionally gated by `lfsr[2]`.
  - Purpose: stress arbiter and master handshakes.
- Undefined: no LFSR logic; timing is exactly as above.

Test Plan:
- Reset then write: AW addr 0x8000_0010 and W data 0x1122334455667788, strb 0xFF in the same cycle → both readies drop next cycle; COMMIT follows. A subsequent read returns 0x1122334455667788, rresp 0, last 1, with `r_valid` exactly RD_LAT cycles after the AR handshake.
- Partial strobe: write 0xAAAA... strb 0x0F to the same address → read returns 0x11223344AAAAAAAA.
- R backpressure: hold `r_ready`=0 for 5 cycles after `r_valid` → data stable, `ar_ready`=0 throughout; `ar_ready`=1 the cycle after the handshake.
- W before AW: W at cycle 0, AW at cycle 3 → `w_ready`=0 in cycles 1-3; write lands; readback matches.
- Out of range: read 0x7FFF_FFF8 → rresp 2'b10, data 0. Write to 0x8000_8000 (DEPTH_LOG2=12) → no array change.
- Reset in R_WAIT with RD_LAT=4 → after reset, `r_valid` stays 0, `ar_ready`=1, and earlier written data is still readable.
